// File: rtl/rgb565_to_rgb_dither_pkg.sv
// Shared video definitions: RGB565 field positions, 4x4 Bayer matrix, channel expanders.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package rgb565_to_rgb_dither_pkg;

    // RGB565 field positions within a 16-bit pixel {R[4:0],G[5:0],B[4:0]}
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Threshold used when ordered dithering is disabled
    localparam logic [7:0] FIXED_THRESHOLD = 8'd128;

    // 4x4 Bayer matrix, index = {y[1:0], x[1:0]}.
    // Listed from index 15 down to 0, i.e. rows 3..0, each row right-to-left.
    // Rows (left to right): {0,8,2,10} {12,4,14,6} {3,11,1,9} {15,7,13,5}
    localparam logic [15:0][3:0] BAYER4 = {
        4'd5,  4'd13, 4'd7,  4'd15,
        4'd9,  4'd1,  4'd11, 4'd3,
        4'd6,  4'd14, 4'd4,  4'd12,
        4'd10, 4'd2,  4'd8,  4'd0
    };

    // Registered contents of the first pipeline stage
    typedef struct packed {
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
        logic [7:0] thr;
        logic       sof;
        logic       eol;
    } stage1_t;

    // Registered contents of the output stage
    typedef struct packed {
        logic r;
        logic g;
        logic b;
        logic sof;
        logic eol;
    } stage2_t;

    // Bit replication keeps 0 -> 0x00 and full-scale -> 0xFF
    function automatic logic [7:0] expand5to8(input logic [4:0] c5);
        return {c5, c5[4:2]};
    endfunction

    function automatic logic [7:0] expand6to8(input logic [5:0] c6);
        return {c6, c6[5:4]};
    endfunction

endpackage

// File: rtl/rgb565_to_rgb_dither_bayer_threshold.sv
// Ordered-dither threshold lookup for a 1-bit quantiser.
// Latency: combinational.
// Backpressure: none (pure function of x/y).
//
// Ports:
//   iX, iY      : low two bits of the pixel coordinate
//   oThreshold  : 8-bit compare threshold (16*M[y][x]+8, or 128 when dithering is off)
module bayer_threshold
    import rgb565_to_rgb_dither_pkg::*;
#(
    parameter int DITHER_EN = 1
) (
    input  logic [1:0] iX,
    input  logic [1:0] iY,
    output logic [7:0] oThreshold
);

    generate
        if (DITHER_EN != 0) begin : gDither
            // 16*M + 8 centres each threshold inside its 1/16 band
            assign oThreshold = {BAYER4[{iY, iX}], 4'b1000};
        end else begin : gFixed
            logic unusedXY;
            assign unusedXY   = ^{iX, iY};
            assign oThreshold = FIXED_THRESHOLD;
        end
    endgenerate

endmodule

// File: rtl/rgb565_to_rgb_dither.sv
// RGB565 to 1-bit-per-channel converter with optional 4x4 ordered dithering.
// Latency: 2 cycles from input acceptance to oValid when not stalled.
// Backpressure: 2-stage stall-able pipeline; full throughput with iReady=1, holds 2 pixels max.
//
// Ports:
//   iClk, iRst          : clock, asynchronous active-high reset
//   iRGB_565/iSof/iValid: input pixel, start-of-frame marker, valid
//   oReady              : input pixel is accepted this cycle when iValid is also high
//   oR/oG/oB/oSof/oEol  : output colour bits, frame start, end of line
//   oValid/iReady       : output handshake
module rgb565_to_rgb_dither
    import rgb565_to_rgb_dither_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int DITHER_EN = 1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [15:0] iRGB_565,
    input  logic        iValid,
    input  logic        iSof,
    output logic        oReady,
    output logic        oR,
    output logic        oG,
    output logic        oB,
    output logic        oSof,
    output logic        oEol,
    output logic        oValid,
    input  logic        iReady
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    logic [XW-1:0] xCnt;
    logic [YW-1:0] yCnt;
    logic [XW-1:0] pixX;
    logic [YW-1:0] pixY;
    logic [1:0]    bayerX;
    logic [1:0]    bayerY;
    logic [7:0]    thr;

    stage1_t s1Dat;
    stage1_t s1Nxt;
    logic    s1Valid;
    stage2_t s2Dat;
    stage2_t s2Nxt;
    logic    s2Valid;

    logic s2Load;
    logic s1Advance;
    logic accept;

    // Handshake: each stage loads when empty or when its successor drains it
    assign s2Load    = !s2Valid || iReady;
    assign s1Advance = s1Valid && s2Load;
    assign oReady    = !s1Valid || s1Advance;
    assign accept    = iValid && oReady;

    // A start-of-frame pixel is forced to the origin regardless of the counters
    assign pixX   = iSof ? '0 : xCnt;
    assign pixY   = iSof ? '0 : yCnt;
    assign bayerX = 2'(pixX);
    assign bayerY = 2'(pixY);

    bayer_threshold #(
        .DITHER_EN (DITHER_EN)
    ) uThreshold (
        .iX         (bayerX),
        .iY         (bayerY),
        .oThreshold (thr)
    );

    // Coordinate counters step from the pixel's own position, so the
    // start-of-frame case falls out of the normal wrap logic.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (accept) begin
            if (pixX == X_LAST) begin
                xCnt <= '0;
                yCnt <= (pixY == Y_LAST) ? '0 : pixY + 1'b1;
            end else begin
                xCnt <= pixX + 1'b1;
                yCnt <= pixY;
            end
        end
    end

    always_comb begin
        s1Nxt     = '0;
        s1Nxt.r8  = expand5to8(iRGB_565[R_MSB:R_LSB]);
        s1Nxt.g8  = expand6to8(iRGB_565[G_MSB:G_LSB]);
        s1Nxt.b8  = expand5to8(iRGB_565[B_MSB:B_LSB]);
        s1Nxt.thr = thr;
        s1Nxt.sof = iSof;
        s1Nxt.eol = (pixX == X_LAST);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1Valid <= 1'b0;
            s1Dat   <= '0;
        end else if (oReady) begin
            s1Valid <= iValid;
            if (iValid) begin
                s1Dat <= s1Nxt;
            end
        end
    end

    always_comb begin
        s2Nxt     = '0;
        s2Nxt.r   = (s1Dat.r8 >= s1Dat.thr);
        s2Nxt.g   = (s1Dat.g8 >= s1Dat.thr);
        s2Nxt.b   = (s1Dat.b8 >= s1Dat.thr);
        s2Nxt.sof = s1Dat.sof;
        s2Nxt.eol = s1Dat.eol;
    end

    // Output register only changes on a load, so a stalled output stays stable
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s2Valid <= 1'b0;
            s2Dat   <= '0;
        end else if (s2Load) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                s2Dat <= s2Nxt;
            end
        end
    end

    assign oValid = s2Valid;
    assign oR     = s2Dat.r;
    assign oG     = s2Dat.g;
    assign oB     = s2Dat.b;
    assign oSof   = s2Dat.sof;
    assign oEol   = s2Dat.eol;

endmodule
